// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding plus the divisor and
// counter-width helpers that the transmitter will reuse.
//   uart_state_t - IDLE, START, DATA, PARITY, STOP, BREAK
//   calc_div     - clocks per oversample tick (integer-truncated, minimum 1)
//   cnt_width    - bits needed for a counter that runs 0..n-1 (minimum 1)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data; dropped when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored while empty
//   rdata      : head entry, forced to 0 while empty
//   full/empty : occupancy flags
//   count      : occupancy 0..DEPTH
// Pointers carry one extra bit so count = wr_ptr - rd_ptr covers 0..DEPTH.
module uart_sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled bit timing, 3-sample majority vote, RX FIFO
// and sticky error flags. Optional parity: define UART_RX_PARITY_EN.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   rx_i          : serial line, idle high, asynchronous
//   read_en_i     : pop FIFO head; takes effect at the clock edge where
//                   read_en_i=1 and ready_o=1 (ready_o low means the pop is
//                   ignored); data_o is valid whenever ready_o=1
//   clr_err_i     : clear sticky flags (a same-cycle new error wins)
//   parity_odd_i  : 1=odd, 0=even parity (parity build only)
//   data_o        : FIFO head (first-word fall-through), 0 when empty
//   ready_o       : FIFO non-empty
//   count_o       : FIFO occupancy
//   frame_err_o   : sticky, stop bit sampled low
//   parity_err_o  : sticky, parity mismatch (tied 0 without parity)
//   overrun_o     : sticky, frame completed while FIFO full
// The FSM state is kept in the named signal 'state' for probing.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          read_en_i,
  input  logic                          clr_err_i,
  input  logic                          parity_odd_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overrun_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DW    = cnt_width(DIV);
  localparam int SW    = cnt_width(OVERSAMPLE);
  localparam int BW    = cnt_width(DATA_BITS);
  localparam int S_LO  = OVERSAMPLE/2 - 1;
  localparam int S_MID = OVERSAMPLE/2;
  localparam int S_HI  = OVERSAMPLE/2 + 1;

  uart_state_t          state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        smp_cnt;
  logic                 smp_a, smp_b;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_req;
  logic                 parity_bad;
  logic                 fifo_full, fifo_empty;
  logic                 fall, tick, vote_now, vote;
  logic                 fe_set, ov_set, push_now;

  assign fall     = rx_prev & ~rx_sync;
  assign tick     = (div_cnt == DW'(DIV - 1));
  // The vote resolves on the third sample tick, using the live third sample.
  assign vote_now = tick && (smp_cnt == SW'(S_HI));
  assign vote     = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);

  assign fe_set   = (state == ST_STOP) && vote_now && !vote;
  assign push_now = (state == ST_STOP) && vote_now && vote && !parity_bad;
  // A full FIFO is never empty, so the pop is accepted whenever read_en_i is high.
  assign ov_set   = push_req && fifo_full && !read_en_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      div_cnt     <= '0;
      smp_cnt     <= '0;
      smp_a       <= 1'b1;
      smp_b       <= 1'b1;
      state       <= ST_IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      push_req    <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      push_req <= push_now;

      // Bit timing restarts at the start edge so votes land mid-bit.
      if (state == ST_IDLE && fall) begin
        div_cnt <= '0;
        smp_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        smp_cnt <= (smp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : smp_cnt + SW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (tick && smp_cnt == SW'(S_LO))  smp_a <= rx_sync;
      if (tick && smp_cnt == SW'(S_MID)) smp_b <= rx_sync;

      case (state)
        ST_IDLE:  if (fall) state <= ST_START;
        ST_START: if (vote_now) begin
          bit_idx <= '0;
          state   <= vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA:  if (vote_now) begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
          if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (vote_now) state <= ST_STOP;
`endif
        ST_STOP:  if (vote_now) state <= vote ? ST_IDLE : ST_BREAK;
        // Stay here until the line returns high so a long break counts once.
        ST_BREAK: if (rx_sync) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      frame_err_o <= (frame_err_o & ~clr_err_i) | fe_set;
      overrun_o   <= (overrun_o & ~clr_err_i) | ov_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_set;
  assign pe_set = (state == ST_STOP) && vote_now && vote && parity_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bad   <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (state == ST_PARITY && vote_now)
        parity_bad <= vote != ((^shreg) ^ parity_odd_i);
      else if (state == ST_START)
        parity_bad <= 1'b0;
      parity_err_o <= (parity_err_o & ~clr_err_i) | pe_set;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
  assign parity_bad        = 1'b0;
  assign parity_err_o      = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (read_en_i),
    .wdata (shreg),
    .rdata (data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_o)
  );

  assign ready_o = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. Time unit treated as 1 ns; 50 MHz clock and
// 781250 baud give an exact divisor of 4 and a 1280 ns bit.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 781250;
  localparam int DBITS    = 8;
  localparam int OS       = 16;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int BIT      = 1000000000 / BAUD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx = 1'b1;
  logic             read_en = 1'b0;
  logic             clr_err = 1'b0;
  logic             parity_odd = 1'b0;
  logic [DBITS-1:0] data;
  logic             ready;
  logic [CW-1:0]    count;
  logic             frame_err, parity_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic             flip_parity = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents and sticky flags.
  logic [DBITS-1:0] exp_q[$];
  logic             exp_fe = 1'b0, exp_pe = 1'b0, exp_ov = 1'b0;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(DBITS),
    .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .read_en_i(read_en), .clr_err_i(clr_err),
    .parity_odd_i(parity_odd), .data_o(data), .ready_o(ready), .count_o(count),
    .frame_err_o(frame_err), .parity_err_o(parity_err), .overrun_o(overrun)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- model ----------------
  function automatic void model_rx(input logic [DBITS-1:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ov = 1'b1;
  endfunction

  function automatic void model_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endfunction

  function automatic logic [CW+3:0] exp_status();
    return {exp_q.size() != 0, CW'(exp_q.size()), exp_fe, exp_pe, exp_ov};
  endfunction

  function automatic logic [DBITS-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [DBITS-1:0] b, input logic stop_bit, input int bit_t);
    rx = 1'b0; #(bit_t);
    for (int i = 0; i < DBITS; i++) begin
      rx = b[i]; #(bit_t);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ parity_odd ^ flip_parity; #(bit_t);
`endif
    rx = stop_bit; #(bit_t);
    rx = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk) read_en = 1'b1;
    @(negedge clk) read_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #5;
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL reset_status: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    vectors++;
    if (data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want %h", data, 8'h00);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #(2*BIT);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, BIT); model_rx(8'hA5); settle();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL single_status: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    vectors++;
    if (data !== exp_head()) begin
      miscompares++;
      $display("FAIL single_data: got %h want %h", data, exp_head());
    end
    pulse_read(); model_pop();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL single_pop: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    pulse_read();
    vectors++;
    if ({ready, count} !== {1'b0, CW'(0)}) begin
      miscompares++;
      $display("FAIL empty_pop: got %b want %b", {ready, count}, {1'b0, CW'(0)});
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(DBITS'(i), 1'b1, BIT); model_rx(DBITS'(i)); settle();
      if (i >= DEPTH) begin
        vectors++;
        if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
          miscompares++;
          $display("FAIL fill_%0d: got %b want %b", i, {ready, count, frame_err, parity_err, overrun}, exp_status());
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (data !== exp_head()) begin
        miscompares++;
        $display("FAIL drain_data_%0d: got %h want %h", i, data, exp_head());
      end
      pulse_read(); model_pop();
    end
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL drained: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    pulse_clr(); exp_ov = 1'b0;
    vectors++;
    if (overrun !== exp_ov) begin
      miscompares++;
      $display("FAIL overrun_clr: got %b want %b", overrun, exp_ov);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, BIT);
    rx = 1'b0;
    exp_fe = 1'b1;
    #(2*BIT);
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL break_start: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    // Clearing mid-break: the rest of the break must not raise the flag again.
    pulse_clr(); exp_fe = 1'b0;
    #(18*BIT);
    rx = 1'b1;
    #(2*BIT);
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL break_end: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    send_frame(8'h55, 1'b1, BIT); model_rx(8'h55); settle();
    vectors++;
    if (data !== exp_head() || count !== CW'(exp_q.size())) begin
      miscompares++;
      $display("FAIL after_break: got %h/%0d want %h/%0d", data, count, exp_head(), exp_q.size());
    end
    send_frame(8'hC3, 1'b0, BIT); exp_fe = 1'b1; settle();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL short_frame_err: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    pulse_clr(); exp_fe = 1'b0;
    vectors++;
    if (frame_err !== exp_fe) begin
      miscompares++;
      $display("FAIL frame_err_clr: got %b want %b", frame_err, exp_fe);
    end
    pulse_read(); model_pop();
  endtask

  task automatic test_glitch_reset();
    rx = 1'b0; #200; rx = 1'b1;
    #(3*BIT);
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL glitch: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    send_frame(8'h33, 1'b1, BIT); model_rx(8'h33); settle();
    // Partial frame, then reset in the middle of it.
    rx = 1'b0; #(BIT);
    rx = 1'b1; #(3*BIT);
    rst_n = 1'b0;
    exp_q.delete(); exp_fe = 1'b0; exp_pe = 1'b0; exp_ov = 1'b0;
    #30;
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun, data} !== {exp_status(), exp_head()}) begin
      miscompares++;
      $display("FAIL mid_frame_reset: got %b want %b", {ready, count, frame_err, parity_err, overrun, data}, {exp_status(), exp_head()});
    end
    #40;
    @(negedge clk) rst_n = 1'b1;
    #(2*BIT);
    send_frame(8'h5A, 1'b1, BIT); model_rx(8'h5A); settle();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun, data} !== {exp_status(), exp_head()}) begin
      miscompares++;
      $display("FAIL post_reset_rx: got %b want %b", {ready, count, frame_err, parity_err, overrun, data}, {exp_status(), exp_head()});
    end
  endtask

  task automatic test_random();
    logic [DBITS-1:0] b;
    for (int n = 0; n < 8; n++) begin
      b = DBITS'($urandom_range(0, 255));
      parity_odd = 1'($urandom_range(0, 1));
      #($urandom_range(0, 3*BIT));
      send_frame(b, 1'b1, BIT); model_rx(b); settle();
      vectors++;
      if ({ready, count, frame_err, parity_err, overrun, data} !== {exp_status(), exp_head()}) begin
        miscompares++;
        $display("FAIL random_%0d: got %b want %b", n, {ready, count, frame_err, parity_err, overrun, data}, {exp_status(), exp_head()});
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_read(); model_pop();
        vectors++;
        if ({ready, count, data} !== {exp_q.size() != 0, CW'(exp_q.size()), exp_head()}) begin
          miscompares++;
          $display("FAIL random_pop_%0d: got %b want %b", n, {ready, count, data}, {exp_q.size() != 0, CW'(exp_q.size()), exp_head()});
        end
      end
    end
    while (exp_q.size() != 0) begin
      pulse_read(); model_pop();
    end
    vectors++;
    if (count !== CW'(0)) begin
      miscompares++;
      $display("FAIL random_drain: got %0d want 0", count);
    end
  endtask

  task automatic test_baud_tolerance();
    int bt[2];
    bt[0] = (BIT * 98) / 100;
    bt[1] = (BIT * 102) / 100;
    parity_odd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h2A, 1'b1, bt[k]); model_rx(8'h2A); settle();
      vectors++;
      if ({ready, count, frame_err, parity_err, overrun, data} !== {exp_status(), exp_head()}) begin
        miscompares++;
        $display("FAIL baud_%0d: got %b want %b", k, {ready, count, frame_err, parity_err, overrun, data}, {exp_status(), exp_head()});
      end
      pulse_read(); model_pop();
      #(BIT);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    parity_odd = 1'b0;
    flip_parity = 1'b0;
    send_frame(8'h07, 1'b1, BIT); model_rx(8'h07); settle();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun, data} !== {exp_status(), exp_head()}) begin
      miscompares++;
      $display("FAIL parity_good: got %b want %b", {ready, count, frame_err, parity_err, overrun, data}, {exp_status(), exp_head()});
    end
    flip_parity = 1'b1;
    send_frame(8'h07, 1'b1, BIT); exp_pe = 1'b1; settle();
    flip_parity = 1'b0;
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL parity_bad: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    pulse_clr(); exp_pe = 1'b0;
    parity_odd = 1'b1;
    send_frame(8'h96, 1'b1, BIT); model_rx(8'h96); settle();
    vectors++;
    if ({ready, count, frame_err, parity_err, overrun} !== exp_status()) begin
      miscompares++;
      $display("FAIL parity_odd: got %b want %b", {ready, count, frame_err, parity_err, overrun}, exp_status());
    end
    while (exp_q.size() != 0) begin
      pulse_read(); model_pop();
    end
    parity_odd = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch_reset();
    test_random();
    test_baud_tolerance();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
